// File: rtl/tsc_readout.sv
// Byte FIFO used by the readout controller: first-word fall-through, registered count.
// Latency: a pushed byte is at the head one cycle after the push edge.
// Backpressure: full is derived from the registered count and the writer must honour it.
module tsc_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         head_vld,
    output logic [W-1:0] head_dat,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;

    always_comb begin
        pop      = pop_rdy && (count_q != '0);
        wr_ptr_d = push_vld ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_vld && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_vld && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_vld = (count_q != '0);
    assign head_dat = head_vld ? mem_q[rd_ptr_q] : '0;
    assign full     = (count_q == CW'(DEPTH));
endmodule

// Readout controller: start a capture, wait for capture-done, drain cache bytes into a FIFO.
// Latency: arm->tsc_start 1 cycle; tsc_cd->tsc_req 2 cycles; tsc_rdy->out_valid 1 cycle.
// Backpressure: no request while the FIFO is full (tsc_sbf=1); downstream pops on out_valid&out_ready.
module tsc_readout #(
    parameter int N_SAMPLES   = 32,
    parameter int BUF_DEPTH   = 16,
    parameter int REQ_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    output logic        tsc_start,
    input  logic        tsc_trd,
    input  logic        tsc_cd,
    input  logic [31:0] tsc_trigtm,
    output logic        tsc_req,
    input  logic        tsc_rdy,
    input  logic [7:0]  tsc_dat,
    input  logic        tsc_sd,
    output logic        tsc_sbf,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] trig_time,
    output logic        trig_seen,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int BCW = $clog2(N_SAMPLES + 1);
    localparam int TW  = $clog2(REQ_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_CD,
        ST_REQ,
        ST_WAIT_RDY,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           err_q, err_d;
    logic [31:0]    trig_time_q, trig_time_d;
    logic           trig_seen_q, trig_seen_d;
    logic           tsc_req_q, tsc_req_d;
    logic           push_vld;
    logic           fifo_full;

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        trig_time_d = trig_time_q;
        trig_seen_d = trig_seen_q;
        push_vld    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    err_d       = 1'b0;
                    trig_seen_d = 1'b0;
                    bcnt_d      = '0;
                    state_d     = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT_CD;
            ST_WAIT_CD: begin
                if (tsc_cd) begin
                    trig_time_d = tsc_trigtm;
                    trig_seen_d = tsc_trd;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                tmo_d = '0;
                // Waiting for tsc_rdy to fall keeps a slow cache from double-answering.
                if (!fifo_full && !tsc_rdy) begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (tsc_rdy) begin
                    push_vld = 1'b1;
                    bcnt_d   = (bcnt_q == BCW'(N_SAMPLES)) ? bcnt_q : bcnt_q + BCW'(1);
                    if (tsc_sd || (bcnt_q >= BCW'(N_SAMPLES - 1))) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (tsc_sd) begin
                    state_d = ST_DONE;
                end else if (tmo_q == TW'(REQ_TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        tsc_req_d = (state_d == ST_WAIT_RDY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bcnt_q      <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            trig_time_q <= '0;
            trig_seen_q <= 1'b0;
            tsc_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            trig_time_q <= trig_time_d;
            trig_seen_q <= trig_seen_d;
            tsc_req_q   <= tsc_req_d;
        end
    end

    tsc_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_dat (tsc_dat),
        .pop_rdy  (out_ready),
        .head_vld (out_valid),
        .head_dat (out_data),
        .full     (fifo_full)
    );

    assign tsc_start = (state_q == ST_START);
    assign done      = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign tsc_req   = tsc_req_q;
    assign tsc_sbf   = fifo_full;
    assign err       = err_q;
    assign trig_time = trig_time_q;
    assign trig_seen = trig_seen_q;
endmodule

// File: tb/tb_tsc_readout.sv
// Directed bench for tsc_readout with a behavioural cache model and a byte scoreboard.
module tb_tsc_readout;
    logic        clk;
    logic        reset;
    logic        arm;
    logic        tsc_start;
    logic        tsc_trd;
    logic        tsc_cd;
    logic [31:0] tsc_trigtm;
    logic        tsc_req;
    logic        tsc_rdy;
    logic [7:0]  tsc_dat;
    logic        tsc_sd;
    logic        tsc_sbf;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] trig_time;
    logic        trig_seen;
    logic        busy;
    logic        done;
    logic        err;

    int          total = 0;
    int          bad   = 0;
    bit          ans_en;
    int          sd_at;
    logic [7:0]  next_dat;
    int          sent;
    int          req_rises;
    int          start_pulses;
    int          done_pulses;
    int          rx_count;
    int          req_run;
    int          max_req_run;
    logic        req_prev;
    logic [7:0]  last_rx;
    logic [31:0] want;
    logic [7:0]  exp_q[$];

    tsc_readout dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .tsc_start  (tsc_start),
        .tsc_trd    (tsc_trd),
        .tsc_cd     (tsc_cd),
        .tsc_trigtm (tsc_trigtm),
        .tsc_req    (tsc_req),
        .tsc_rdy    (tsc_rdy),
        .tsc_dat    (tsc_dat),
        .tsc_sd     (tsc_sd),
        .tsc_sbf    (tsc_sbf),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .trig_time  (trig_time),
        .trig_seen  (trig_seen),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
        end
    endtask

    // Cache model answers one cycle after tsc_req; monitor samples on the falling edge.
    initial begin
        tsc_rdy  = 1'b0;
        tsc_sd   = 1'b0;
        tsc_dat  = 8'h00;
        req_prev = 1'b0;
        req_run  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset || tsc_rdy) begin
                tsc_rdy = 1'b0;
                tsc_sd  = 1'b0;
            end else if (tsc_req && ans_en) begin
                tsc_dat = next_dat;
                tsc_rdy = 1'b1;
                sent++;
                tsc_sd  = (sent == sd_at);
                exp_q.push_back(next_dat);
                next_dat++;
            end
            @(negedge clk);
            if (tsc_req && !req_prev) req_rises++;
            req_prev = tsc_req;
            req_run  = tsc_req ? req_run + 1 : 0;
            if (req_run > max_req_run) max_req_run = req_run;
            if (tsc_start) start_pulses++;
            if (done) done_pulses++;
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) want = {24'h0, exp_q.pop_front()};
                else want = 32'hDEAD_BEEF;
                check("out_data", {24'h0, out_data}, want);
                last_rx = out_data;
                rx_count++;
            end
        end
    end

    task automatic start_readout(input logic [31:0] tm, input logic trd);
        req_rises    = 0;
        start_pulses = 0;
        done_pulses  = 0;
        rx_count     = 0;
        sent         = 0;
        next_dat     = 8'h00;
        max_req_run  = 0;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        check("start_pulse", tsc_start, 1);
        check("busy_in_start", busy, 1);
        tick;
        check("start_one_cycle", tsc_start, 0);
        tsc_trigtm = tm;
        tsc_trd    = trd;
        tsc_cd     = 1'b1;
        tick;
        tsc_cd     = 1'b0;
        tsc_trd    = 1'b0;
        tsc_trigtm = 32'h0;
        check("trig_time_latch", trig_time, tm);
        check("trig_seen_latch", trig_seen, trd);
        check("req_low_after_cd", tsc_req, 0);
        tick;
        check("req_issue", tsc_req, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || out_valid) && n < 2000) begin
            tick;
            n++;
        end
        check(tag, (n < 2000), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int n;
        reset      = 1'b1;
        arm        = 1'b0;
        tsc_trd    = 1'b0;
        tsc_cd     = 1'b0;
        tsc_trigtm = 32'h0;
        out_ready  = 1'b0;
        ans_en     = 1'b0;
        sd_at      = 0;
        #3 reset = 1'b0;
        repeat (3) tick;
        check("reset_flags", {24'h0, tsc_start, tsc_req, tsc_sbf, out_valid,
                              trig_seen, busy, done, err}, 0);
        check("reset_trig_time", trig_time, 0);
        check("reset_out_data", out_data, 0);
        reset = 1'b1;
        tick;
        check("idle_after_release", busy, 0);

        // Nominal 32-byte readout.
        out_ready = 1'b1;
        ans_en    = 1'b1;
        start_readout(32'h0000_1234, 1'b1);
        wait_idle("nominal_drain_bound");
        check("nominal_trig_time", trig_time, 32'h0000_1234);
        check("nominal_trig_seen", trig_seen, 1);
        check("nominal_bytes", rx_count, 32);
        check("nominal_last_byte", last_rx, 31);
        check("nominal_requests", req_rises, 32);
        check("nominal_done", done_pulses, 1);
        check("nominal_starts", start_pulses, 1);
        check("nominal_err", err, 0);

        // Send-done arrives with the 10th byte.
        sd_at = 10;
        start_readout(32'hABCD_0001, 1'b0);
        wait_idle("early_drain_bound");
        check("early_trig_seen", trig_seen, 0);
        check("early_bytes", rx_count, 10);
        check("early_last_byte", last_rx, 9);
        check("early_requests", req_rises, 10);
        check("early_done", done_pulses, 1);

        // Downstream stalled: the FIFO fills and requests stop.
        sd_at     = 0;
        out_ready = 1'b0;
        start_readout(32'h0000_0BB0, 1'b1);
        n = 0;
        while (!tsc_sbf && n < 500) begin
            tick;
            n++;
        end
        check("bp_full_bound", (n < 500), 1);
        repeat (20) tick;
        check("bp_sbf_held", tsc_sbf, 1);
        check("bp_req_low", tsc_req, 0);
        check("bp_requests", req_rises, 16);
        check("bp_nothing_read", rx_count, 0);
        out_ready = 1'b1;
        wait_idle("bp_drain_bound");
        check("bp_sbf_clear", tsc_sbf, 0);
        check("bp_bytes", rx_count, 32);
        check("bp_last_byte", last_rx, 31);
        check("bp_requests_total", req_rises, 32);
        check("bp_done", done_pulses, 1);

        // Cache never answers.
        ans_en = 1'b0;
        start_readout(32'h0000_0077, 1'b0);
        n = 0;
        while (busy && n < 1000) begin
            tick;
            n++;
        end
        check("tmo_bound", (n < 1000), 1);
        check("tmo_req_high_cycles", max_req_run, 255);
        check("tmo_err", err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_req_low", tsc_req, 0);
        check("tmo_no_done", done_pulses, 0);
        check("tmo_requests", req_rises, 1);
        ans_en = 1'b1;
        start_readout(32'h0000_0078, 1'b1);
        check("tmo_err_cleared", err, 0);
        wait_idle("tmo_rerun_bound");
        check("tmo_rerun_bytes", rx_count, 32);
        check("tmo_rerun_done", done_pulses, 1);

        // Reset lands with three bytes buffered.
        out_ready = 1'b1;
        start_readout(32'h5555_AAAA, 1'b1);
        n = 0;
        while (rx_count < 2 && n < 200) begin
            tick;
            n++;
        end
        out_ready = 1'b0;
        n = 0;
        while (sent < 5 && n < 200) begin
            tick;
            n++;
        end
        check("mid_bound", (n < 200), 1);
        tick;
        tick;
        check("mid_popped", rx_count, 2);
        check("mid_buffered", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        check("async_reset_flags", {24'h0, tsc_start, tsc_req, tsc_sbf, out_valid,
                                    trig_seen, busy, done, err}, 0);
        check("async_reset_trig_time", trig_time, 0);
        check("async_reset_out_data", out_data, 0);
        tick;
        reset = 1'b1;
        tick;

        // Clean readout after reset, with a stray arm while a request is open.
        out_ready = 1'b1;
        start_readout(32'h0000_0C0C, 1'b1);
        arm = 1'b1;
        tick;
        arm = 1'b0;
        wait_idle("post_reset_bound");
        check("post_reset_bytes", rx_count, 32);
        check("post_reset_last_byte", last_rx, 31);
        check("post_reset_requests", req_rises, 32);
        check("post_reset_done", done_pulses, 1);
        check("ignored_arm_starts", start_pulses, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
